// File: rtl/step_period_meter.sv
// rtl/step_period_meter.sv - measures half-period of an async square wave, recovers lock and stall state.
module step_period_meter #(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255,
  parameter int LOCK_COUNT  = 3,
  parameter int TOL         = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sig_in,
  output logic [W-1:0] half_period,
  output logic         meas_valid,
  output logic         meas_level,
  output logic         locked,
  output logic         timeout,
  output logic [15:0]  edge_count
);

  localparam int MW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [W-1:0]  TIMEOUT_W = W'(TIMEOUT);
  localparam logic [W-1:0]  TOL_W     = W'(TOL);
  localparam logic [MW-1:0] LOCK_W    = MW'(LOCK_COUNT);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [W-1:0]           cnt_q, cnt_d;
  logic [W-1:0]           hp_q, hp_d;
  logic [MW-1:0]          match_q, match_d;
  logic                   valid_q, valid_d;
  logic                   level_q, level_d;
  logic                   locked_q, locked_d;
  logic                   timeout_q, timeout_d;
  logic [15:0]            ecnt_q, ecnt_d;
  logic                   sync_out;
  logic                   edge_det;
  logic [W-1:0]           diff;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign edge_det = sync_out ^ prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      hp_q      <= '0;
      match_q   <= '0;
      valid_q   <= 1'b0;
      level_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
      ecnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q    <= sync_out;
      cnt_q     <= cnt_d;
      hp_q      <= hp_d;
      match_q   <= match_d;
      valid_q   <= valid_d;
      level_q   <= level_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
      ecnt_q    <= ecnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hp_d      = hp_q;
    match_d   = match_q;
    valid_d   = 1'b0;
    level_d   = level_q;
    locked_d  = locked_q;
    timeout_d = timeout_q;
    ecnt_d    = ecnt_q;
    diff      = (cnt_q >= hp_q) ? (cnt_q - hp_q) : (hp_q - cnt_q);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (edge_det) begin
          state_d   = MEASURE;
          cnt_d     = W'(1);
          ecnt_d    = ecnt_q + 16'd1;
          timeout_d = 1'b0;
        end
      end
      MEASURE: begin
        if (edge_det) begin
          hp_d    = cnt_q;
          level_d = prev_q;
          valid_d = 1'b1;
          ecnt_d  = ecnt_q + 16'd1;
          cnt_d   = W'(1);
          // match_q == 0 only before the first measurement after IDLE
          if (match_q == '0) begin
            match_d = MW'(1);
          end else if (diff <= TOL_W) begin
            match_d = (match_q < LOCK_W) ? match_q + MW'(1) : match_q;
          end else begin
            match_d = MW'(1);
          end
          locked_d = (match_d >= LOCK_W);
        end else if (cnt_q == TIMEOUT_W) begin
          state_d   = IDLE;
          cnt_d     = '0;
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          match_d   = '0;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign half_period = hp_q;
  assign meas_valid  = valid_q;
  assign meas_level  = level_q;
  assign locked      = locked_q;
  assign timeout     = timeout_q;
  assign edge_count  = ecnt_q;

endmodule

// File: tb/tb_step_period_meter.sv
// tb/tb_step_period_meter.sv - scoreboard bench for step_period_meter (TOL=0 and TOL=1 instances).
module tb_step_period_meter;

  localparam int TIMEOUT = 255;
  localparam int LOCK    = 3;

  typedef struct {
    int hp;
    bit lvl;
    bit lk;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig_in = 1'b0;

  logic [7:0]  hp0, hp1;
  logic        mv0, mv1, ml0, ml1, lk0, lk1, to0, to1;
  logic [15:0] ec0, ec1;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  exp_t e0, e1;
  int   m_match[2];
  int   m_hp[2];
  bit   m_active;
  int   m_edges;
  int   last_cyc;

  step_period_meter #(.W(8), .SYNC_STAGES(2), .TIMEOUT(TIMEOUT), .LOCK_COUNT(LOCK), .TOL(0)) dut0 (
    .clk(clk), .rst(rst), .sig_in(sig_in), .half_period(hp0), .meas_valid(mv0),
    .meas_level(ml0), .locked(lk0), .timeout(to0), .edge_count(ec0)
  );

  step_period_meter #(.W(8), .SYNC_STAGES(2), .TIMEOUT(TIMEOUT), .LOCK_COUNT(LOCK), .TOL(1)) dut1 (
    .clk(clk), .rst(rst), .sig_in(sig_in), .half_period(hp1), .meas_valid(mv1),
    .meas_level(ml1), .locked(lk1), .timeout(to1), .edge_count(ec1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mv0) begin
      checks++;
      if (sb0.size() == 0) begin
        errors++;
        $display("FAIL dut0_unexpected_meas cycle %0d got hp=%0d", cyc, hp0);
      end else begin
        e0 = sb0.pop_front();
        if (hp0 !== 8'(e0.hp) || ml0 !== e0.lvl || lk0 !== e0.lk || cyc != e0.cyc) begin
          errors++;
          $display("FAIL dut0_meas got hp=%0d lvl=%0b lk=%0b cyc=%0d expected hp=%0d lvl=%0b lk=%0b cyc=%0d",
                   hp0, ml0, lk0, cyc, e0.hp, e0.lvl, e0.lk, e0.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mv1) begin
      checks++;
      if (sb1.size() == 0) begin
        errors++;
        $display("FAIL dut1_unexpected_meas cycle %0d got hp=%0d", cyc, hp1);
      end else begin
        e1 = sb1.pop_front();
        if (hp1 !== 8'(e1.hp) || ml1 !== e1.lvl || lk1 !== e1.lk || cyc != e1.cyc) begin
          errors++;
          $display("FAIL dut1_meas got hp=%0d lvl=%0b lk=%0b cyc=%0d expected hp=%0d lvl=%0b lk=%0b cyc=%0d",
                   hp1, ml1, lk1, cyc, e1.hp, e1.lvl, e1.lk, e1.cyc);
        end
      end
    end
  end

  // Toggle sig_in n cycles after the previous toggle and predict the measurement it closes.
  task automatic drive_toggle(input int n);
    int   gap;
    int   diff;
    exp_t e;
    while (cyc < last_cyc + n) @(negedge clk);
    gap = cyc - last_cyc;
    if (m_active && gap > TIMEOUT) begin
      m_active = 1'b0;
      m_match  = '{0, 0};
    end
    if (!m_active) begin
      m_active = 1'b1;
    end else begin
      for (int d = 0; d < 2; d++) begin
        diff = gap - m_hp[d];
        if (diff < 0) diff = -diff;
        if (m_match[d] == 0) m_match[d] = 1;
        else if (diff <= d) m_match[d] = (m_match[d] < LOCK) ? m_match[d] + 1 : m_match[d];
        else m_match[d] = 1;
        m_hp[d] = gap;
        e.hp  = gap;
        e.lvl = sig_in;
        e.lk  = (m_match[d] >= LOCK);
        e.cyc = cyc + 3;
        if (d == 0) sb0.push_back(e);
        else sb1.push_back(e);
      end
    end
    m_edges++;
    last_cyc = cyc;
    sig_in = ~sig_in;
  endtask

  task automatic settle_and_check_drained(input string name);
    repeat (6) @(negedge clk);
    checks++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      errors++;
      $display("FAIL %s_drained pending dut0=%0d dut1=%0d expected 0", name, sb0.size(), sb1.size());
    end
    checks++;
    if (ec0 !== 16'(m_edges)) begin
      errors++;
      $display("FAIL %s_edge_count got %0d expected %0d", name, ec0, m_edges);
    end
  endtask

  task automatic do_reset(input bit lvl);
    @(negedge clk);
    sig_in = lvl;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({hp0, mv0, ml0, lk0, to0, ec0, hp1, mv1, ml1, lk1, to1, ec1} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got hp=%0d mv=%0b ml=%0b lk=%0b to=%0b ec=%0d expected all 0",
               hp0, mv0, ml0, lk0, to0, ec0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb0.delete();
    sb1.delete();
    m_match  = '{0, 0};
    m_hp     = '{0, 0};
    m_active = lvl;
    m_edges  = lvl ? 1 : 0;
    last_cyc = cyc;
  endtask

  task automatic test_reset;
    do_reset(1'b0);
    repeat (5) @(negedge clk);
    checks++;
    if ({hp0, mv0, ml0, lk0, to0, ec0} !== '0) begin
      errors++;
      $display("FAIL reset_idle got hp=%0d ec=%0d lk=%0b to=%0b expected all 0", hp0, ec0, lk0, to0);
    end
  endtask

  task automatic test_reset_high;
    do_reset(1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (ec0 !== 16'd0) begin
      errors++;
      $display("FAIL reset_high_early_edge got %0d expected 0", ec0);
    end
    @(negedge clk);
    checks++;
    if (ec0 !== 16'd1 || ec1 !== 16'd1 || mv0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_high_edge got ec=%0d/%0d mv=%0b expected ec=1/1 mv=0", ec0, ec1, mv0);
    end
    settle_and_check_drained("reset_high");
  endtask

  task automatic test_steady;
    do_reset(1'b0);
    repeat (10) drive_toggle(25);
    settle_and_check_drained("steady");
    checks++;
    if (ec0 !== 16'd10 || lk0 !== 1'b1 || hp0 !== 8'd25) begin
      errors++;
      $display("FAIL steady_final got ec=%0d lk=%0b hp=%0d expected ec=10 lk=1 hp=25", ec0, lk0, hp0);
    end
  endtask

  task automatic test_rate_change;
    repeat (4) drive_toggle(40);
    settle_and_check_drained("rate_change");
    checks++;
    if (lk0 !== 1'b1 || hp0 !== 8'd40) begin
      errors++;
      $display("FAIL rate_change_final got lk=%0b hp=%0d expected lk=1 hp=40", lk0, hp0);
    end
  endtask

  task automatic test_tolerance;
    for (int i = 0; i < 8; i++) drive_toggle((i % 2) ? 26 : 25);
    settle_and_check_drained("tolerance");
    checks++;
    if (lk1 !== 1'b1 || lk0 !== 1'b0) begin
      errors++;
      $display("FAIL tolerance_lock got tol1=%0b tol0=%0b expected tol1=1 tol0=0", lk1, lk0);
    end
  endtask

  task automatic test_stall;
    repeat (5) drive_toggle(25);
    repeat (257) @(negedge clk);
    checks++;
    if (to0 !== 1'b0 || lk0 !== 1'b1) begin
      errors++;
      $display("FAIL stall_early got to=%0b lk=%0b expected to=0 lk=1", to0, lk0);
    end
    @(negedge clk);
    checks++;
    if (to0 !== 1'b1 || lk0 !== 1'b0 || hp0 !== 8'd25 || to1 !== 1'b1) begin
      errors++;
      $display("FAIL stall_timeout got to=%0b lk=%0b hp=%0d to1=%0b expected to=1 lk=0 hp=25 to1=1",
               to0, lk0, hp0, to1);
    end
    drive_toggle(300);
    repeat (2) @(negedge clk);
    checks++;
    if (to0 !== 1'b1) begin
      errors++;
      $display("FAIL stall_hold got to=%0b expected 1", to0);
    end
    @(negedge clk);
    checks++;
    if (to0 !== 1'b0) begin
      errors++;
      $display("FAIL stall_clear got to=%0b expected 0", to0);
    end
    drive_toggle(25);
    settle_and_check_drained("stall");
  endtask

  task automatic test_boundary;
    repeat (3) drive_toggle(TIMEOUT);
    settle_and_check_drained("boundary_max");
    checks++;
    if (to0 !== 1'b0 || hp0 !== 8'd255) begin
      errors++;
      $display("FAIL boundary_max got to=%0b hp=%0d expected to=0 hp=255", to0, hp0);
    end
    repeat (12) drive_toggle(1);
    settle_and_check_drained("boundary_min");
    checks++;
    if (hp0 !== 8'd1 || lk0 !== 1'b1) begin
      errors++;
      $display("FAIL boundary_min got hp=%0d lk=%0b expected hp=1 lk=1", hp0, lk0);
    end
  endtask

  task automatic test_reset_mid;
    repeat (4) drive_toggle(25);
    repeat (10) @(negedge clk);
    checks++;
    if (lk0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_prelock got %0b expected 1", lk0);
    end
    do_reset(1'b0);
    drive_toggle(20);
    drive_toggle(20);
    settle_and_check_drained("reset_mid");
    checks++;
    if (hp0 !== 8'd20 || lk0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_final got hp=%0d lk=%0b expected hp=20 lk=0", hp0, lk0);
    end
  endtask

  initial begin
    m_match  = '{0, 0};
    m_hp     = '{0, 0};
    m_active = 1'b0;
    m_edges  = 0;
    last_cyc = 0;
    test_reset();
    test_reset_high();
    test_steady();
    test_rate_change();
    test_tolerance();
    test_stall();
    test_boundary();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_period_meter.md
Name: step_period_meter

Overview:
- Receive-side counterpart of the step/clock square-wave generator.
- Samples an asynchronous square wave (`sig_in`), detects every transition, and measures the half-period between successive transitions in `clk` cycles.
- Recovers the generator's divide parameter, flags a stable (locked) rate and detects a stalled signal (timeout).
- Sits on the motion-control side for closed-loop checking of step-rate generators and for bench self-test.

Parameters:
- W, 8, width of measured half-period and internal interval counter.
- SYNC_STAGES, 2, synchronizer flops on `sig_in` (minimum 2).
- TIMEOUT, 255, cycles without an edge before declaring stall; must be <= 2^W-1 and >= 2.
- LOCK_COUNT, 3, consecutive in-tolerance measurements required to assert `locked` (minimum 1).
- TOL, 0, max absolute difference between consecutive measurements still counted as a match.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- sig_in  in  1  asynchronous square wave under measurement.
- half_period  out  W  last measured interval between edges, in clk cycles.
- meas_valid  out  1  one-cycle pulse: `half_period` updated this cycle.
- meas_level  out  1  level of `sig_in` during the measured interval (level before the closing edge).
- locked  out  1  rate stable per LOCK_COUNT/TOL.
- timeout  out  1  sticky stall flag.
- edge_count  out  16  count of detected edges.

Behaviour:
- **Reset:** all outputs 0; sync chain and previous-level flop 0; counter 0; match counter 0; state IDLE. A reset mid-interval discards the partial interval.
- **Synchronizer and edge detect:**
  - `sig_in` passes through SYNC_STAGES flops; `edge` = sync_out XOR prev_level (registered).
  - An edge is seen SYNC_STAGES+1 cycles after an `sig_in` toggle. The constant offset cancels in intervals.
  - If `sig_in` is high at reset release, a rising edge is detected; it is handled as a normal edge.
- **Interval counter `cnt`:** set to 1 on an edge cycle; otherwise increments by 1 while state is not IDLE. It never exceeds TIMEOUT, so no wrap is possible.
- **State IDLE:** `cnt` held at 0. On edge: go to MEASURE, `cnt`=1, `edge_count`++, no measurement, `timeout` cleared.
- **State MEASURE (including locked):**
  - On edge: `half_period` <= `cnt`, `meas_level` <= prev_level, `meas_valid`=1 in the next cycle (registered), `edge_count`++, `cnt`=1.
  - Lock update on the same edge: if this is the first measurement since IDLE, match counter = 1. Else if |`cnt` - previous `half_period`| <= TOL, match counter increments, saturating at LOCK_COUNT; otherwise match counter = 1.
  - `locked` = (match counter >= LOCK_COUNT), registered alongside `half_period`.
- **Timeout:**
  - In MEASURE, if `cnt` == TIMEOUT and no edge this cycle: go to IDLE, `timeout`=1, `locked`=0, match counter=0. `half_period` retains its last value.
  - Edge and `cnt` == TIMEOUT in the same cycle: the edge wins, and the measurement is TIMEOUT.
  - `timeout` stays set until the next detected edge.
- **Locked with LOCK_COUNT=1:** `locked` asserts with the first measurement.
- **`edge_count`:** wraps 65535 -> 0 with no flag.
- **`meas_valid`:** never asserted in consecutive cycles unless edges are one cycle apart; the minimum measurable interval is 1.

Test Plan:
- **Reset values:** assert `rst` 3 cycles with `sig_in`=0 -> all outputs 0. With `sig_in`=1 at release -> `edge_count`=1 after SYNC_STAGES+1 cycles, `meas_valid` stays 0.
- **Steady rate:** toggle `sig_in` every 25 clk cycles, 10 toggles -> `meas_valid` pulses every 25 cycles starting at the 2nd edge, `half_period`=25, `meas_level` alternating. `locked` rises with the 3rd measurement (4th edge). `edge_count`=10.
- **Rate change:** after lock at 25, switch to 40-cycle half-period -> first 40 measurement drops `locked`, which reasserts on the 3rd consecutive 40. With TOL=1, alternating 25/26 keeps `locked` high.
- **Stall:** lock at 25, then hold `sig_in` constant -> `timeout`=1 and `locked`=0 exactly TIMEOUT cycles after the last edge; `half_period` stays 25. The next edge clears `timeout` and gives no measurement. The following edge measures normally.
- **Boundary:** edges exactly TIMEOUT (255) apart -> `half_period`=255, no timeout. Edges 1 cycle apart (`sig_in` toggles every clk) -> `half_period`=1 every cycle.
- **Reset mid-operation:** assert `rst` while locked, mid-interval -> next cycle all outputs 0. Resume toggling -> first post-reset edge produces no measurement, and the second produces the correct interval.
